// File: rtl/decode_ooo_queue.sv
// N-wide in-order queue between the decoder and the ooo core; absorbs stalls, flushes on squash.
// Optional same-cycle bypass into an empty queue: define DECODE_OOO_QUEUE_BYPASS_EN.
module decode_ooo_queue #(
  parameter int N      = 2,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    squash,
  input  logic                    stall,
  input  logic [N-1:0]            in_valid,
  input  logic [N*DATA_W-1:0]     in_data,
  output logic                    in_ready,
  output logic [N-1:0]            out_valid,
  output logic [N*DATA_W-1:0]     out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;

  logic [DATA_W-1:0] comp_data [N];
  logic [CW-1:0]     enq_cnt;
  logic [CW-1:0]     enq_n;
  logic [CW-1:0]     deq_n;
  logic [CW-1:0]     count_next;
  logic              bypass_hit;

  // Conservative: only the registered count decides whether a full group fits.
  assign in_ready = (count <= CW'(DEPTH - N));

  // Pack the set slots of in_valid into consecutive positions, oldest first.
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < N; i++) comp_data[i] = '0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i]) begin
        comp_data[k] = in_data[i*DATA_W +: DATA_W];
        k = k + 1;
      end
    end
    enq_cnt = CW'(k);
  end

`ifdef DECODE_OOO_QUEUE_BYPASS_EN
  assign bypass_hit = (count == '0) && !squash && in_ready;
`else
  assign bypass_hit = 1'b0;
`endif

  always_comb begin
    enq_n = '0;
    deq_n = '0;
    if (!squash) begin
      if (in_ready) enq_n = enq_cnt;
      if (!stall) deq_n = (count < CW'(N)) ? count : CW'(N);
      // Bypassed slots that the core takes this cycle never touch the buffer.
      if (bypass_hit && !stall) enq_n = '0;
    end
    count_next = count + enq_n - deq_n;
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (bypass_hit) begin
        out_valid[i]                 = (CW'(i) < enq_cnt);
        out_data[i*DATA_W +: DATA_W] = comp_data[i];
      end else begin
        out_valid[i]                 = (CW'(i) < count) && !squash;
        out_data[i*DATA_W +: DATA_W] = mem[head + AW'(i)];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else if (squash) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      head        <= head + AW'(deq_n);
      tail        <= tail + AW'(enq_n);
      count       <= count_next;
      almost_full <= (count_next > CW'(DEPTH - 2*N));
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < enq_n) mem[tail + AW'(i)] <= comp_data[i];
    end
  end

endmodule

// File: tb/tb_decode_ooo_queue.sv
// Directed self-checking bench for decode_ooo_queue (N=2, DEPTH=8, default build without bypass).
module tb_decode_ooo_queue;

  localparam int N      = 2;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;

  logic                   clock;
  logic                   reset_n;
  logic                   squash;
  logic                   stall;
  logic [N-1:0]           in_valid;
  logic [N*DATA_W-1:0]    in_data;
  logic                   in_ready;
  logic [N-1:0]           out_valid;
  logic [N*DATA_W-1:0]    out_data;
  logic [$clog2(DEPTH):0] count;
  logic                   almost_full;

  int tests_run;
  int tests_failed;

  decode_ooo_queue #(.N(N), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .squash      (squash),
    .stall       (stall),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle's worth of inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic sq, input logic st, input logic [N-1:0] iv,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    squash   = sq;
    stall    = st;
    in_valid = iv;
    in_data  = {d1, d0};
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] want);
    tests_run++;
    assert (got === want) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] slot(input int i);
    return out_data[i*DATA_W +: DATA_W];
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0);
    #1;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_almost_full", 64'(almost_full), 64'd0);
    #5 reset_n = 1'b1;
    tick();

    // Streaming A,B then C,D with no stall
    applyStimulus(1'b0, 1'b0, 2'b11, 64'hA, 64'hB);
    checkOutput("empty_out_valid", 64'(out_valid), 64'd0);
    tick();
    checkOutput("stream1_count", 64'(count), 64'd2);
    checkOutput("stream1_valid", 64'(out_valid), 64'd3);
    checkOutput("stream1_d0", slot(0), 64'hA);
    checkOutput("stream1_d1", slot(1), 64'hB);
    applyStimulus(1'b0, 1'b0, 2'b11, 64'hC, 64'hD);
    tick();
    checkOutput("stream2_count", 64'(count), 64'd2);
    checkOutput("stream2_d0", slot(0), 64'hC);
    checkOutput("stream2_d1", slot(1), 64'hD);
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0);
    tick();
    checkOutput("drain_count", 64'(count), 64'd0);

    // Fill under stall; storage wraps from index 4 around to 3
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b1, 2'b11, 64'h100 + 64'(2*c), 64'h101 + 64'(2*c));
      tick();
      checkOutput($sformatf("fill%0d_count", c), 64'(count), 64'(2*(c+1)));
      checkOutput($sformatf("fill%0d_af", c), 64'(almost_full), (c >= 2) ? 64'd1 : 64'd0);
    end
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_d0", slot(0), 64'h100);
    checkOutput("full_d1", slot(1), 64'h101);
    applyStimulus(1'b0, 1'b1, 2'b11, 64'hDEAD, 64'hBEEF);
    tick();
    checkOutput("full_ignore_count", 64'(count), 64'd8);
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0);
    tick();
    checkOutput("deq_full_count", 64'(count), 64'd6);
    checkOutput("deq_full_d0", slot(0), 64'h102);
    checkOutput("deq_full_d1", slot(1), 64'h103);
    checkOutput("deq_full_af", 64'(almost_full), 64'd1);

    // Build count=5, then async reset mid-cycle
    applyStimulus(1'b0, 1'b1, 2'b01, 64'h200, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0);
    tick();
    checkOutput("pre_reset_count", 64'(count), 64'd5);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_count", 64'(count), 64'd0);
    checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_ready", 64'(in_ready), 64'd1);
    #3 reset_n = 1'b1;
    tick();

    // Non-contiguous mask 2'b10 compacts to slot 0
    applyStimulus(1'b0, 1'b0, 2'b10, 64'h999, 64'h5A);
    tick();
    checkOutput("sparse_count", 64'(count), 64'd1);
    checkOutput("sparse_valid", 64'(out_valid), 64'd1);
    checkOutput("sparse_d0", slot(0), 64'h5A);

    // Reach count=6 then squash with enq and no stall
    applyStimulus(1'b0, 1'b1, 2'b11, 64'h300, 64'h301);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b11, 64'h302, 64'h303);
    tick();
    applyStimulus(1'b0, 1'b1, 2'b01, 64'h304, '0);
    tick();
    checkOutput("pre_squash_count", 64'(count), 64'd6);
    applyStimulus(1'b1, 1'b0, 2'b11, 64'h400, 64'h401);
    checkOutput("squash_valid", 64'(out_valid), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0);
    checkOutput("post_squash_count", 64'(count), 64'd0);
    checkOutput("post_squash_valid", 64'(out_valid), 64'd0);
    checkOutput("post_squash_ready", 64'(in_ready), 64'd1);

    // Walk head to index 7 with one entry M, then enqueue E,F across the wrap
    applyStimulus(1'b0, 1'b0, 2'b11, 64'h500, 64'h501);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b11, 64'h502, 64'h503);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b11, 64'h504, 64'h505);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b01, 64'h506, '0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b01, 64'h77, '0);
    tick();
    checkOutput("wrap_pre_count", 64'(count), 64'd1);
    applyStimulus(1'b0, 1'b1, 2'b11, 64'hE, 64'hF);
    checkOutput("wrap_pre_d0", slot(0), 64'h77);
    checkOutput("wrap_pre_valid", 64'(out_valid), 64'd1);
    tick();
    checkOutput("wrap_count", 64'(count), 64'd3);
    checkOutput("wrap_d0", slot(0), 64'h77);
    checkOutput("wrap_d1", slot(1), 64'hE);
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0);
    tick();
    checkOutput("wrap_tail_count", 64'(count), 64'd1);
    checkOutput("wrap_tail_d0", slot(0), 64'hF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
